y_requant_out: RTL and testbench

Y_REQUANT_OUT -- requirements
Module: y_requant_out

---
 rtl/conv_pkg.sv | 16 +
 rtl/y_fifo.sv | 48 ++++
 rtl/y_requant_out.sv | 95 +++++++++
 tb/tb_y_requant_out.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared convolution-pipeline constants: accumulator width, output width and
// the number of valid outputs per frame derived from signal and filter sizes.
package conv_pkg;

  localparam int X_SIZE    = 100;
  localparam int F_SIZE    = 4;
  localparam int ACC_SIZE  = 21;
  localparam int OUT_WIDTH = 8;
  localparam int Y_COUNT   = X_SIZE - F_SIZE + 1;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/y_fifo.sv
// Small synchronous FIFO for requantized samples. Pointers carry one extra
// wrap bit so that full and empty are distinguished without a level counter.
// DEPTH must be a power of two and at least 2.
module y_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are left unreset since they are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/y_requant_out.sv
// Output stage of the convolution: clamps negatives, rounds and right-shifts
// each accumulator sample to an unsigned byte, buffers it in a FIFO and tags
// the last sample of every frame.
module y_requant_out
  import conv_pkg::cnt_width;
#(
  parameter int ACC_SIZE   = conv_pkg::ACC_SIZE,
  parameter int OUT_WIDTH  = conv_pkg::OUT_WIDTH,
  parameter int SHIFT      = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int Y_COUNT    = conv_pkg::Y_COUNT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid_y,
  output logic                       s_ready_y,
  input  logic signed [ACC_SIZE-1:0] s_data_in_y,
  output logic                       m_valid_z,
  input  logic                       m_ready_z,
  output logic [OUT_WIDTH-1:0]       m_data_out_z,
  output logic                       m_last_z
);

  localparam int                CNT_W    = cnt_width(Y_COUNT);
  localparam logic [ACC_SIZE:0] HALF     = (ACC_SIZE+1)'(1) << (SHIFT-1);
  localparam logic [ACC_SIZE:0] MAX_Q    = (ACC_SIZE+1)'((64'd1 << OUT_WIDTH) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(Y_COUNT-1);

  // Round-half-up then shift; one guard bit keeps the largest positive input from overflowing.
  function automatic logic [ACC_SIZE:0] round_shift(input logic signed [ACC_SIZE-1:0] x);
    logic [ACC_SIZE:0] ext;
    ext = {1'b0, x};
    return (ext + HALF) >> SHIFT;
  endfunction

  // Clip to the largest representable unsigned output.
  function automatic logic [OUT_WIDTH-1:0] sat_out(input logic [ACC_SIZE:0] v);
    if (v > MAX_Q) return {OUT_WIDTH{1'b1}};
    return v[OUT_WIDTH-1:0];
  endfunction

  // ---- stage p0: combinational requantization of the incoming sample ----
  logic signed [ACC_SIZE-1:0] x_p0;
  logic [OUT_WIDTH-1:0]       q_p0;
  logic                       vld_p0;
  logic                       full;
  logic                       empty;

  assign x_p0      = s_data_in_y;
  assign s_ready_y = !full;
  assign vld_p0    = s_valid_y && s_ready_y;

  // Negative accumulators clamp to zero; others round, shift and saturate.
  always_comb begin
    q_p0 = '0;
    if (!x_p0[ACC_SIZE-1]) q_p0 = sat_out(round_shift(x_p0));
  end

  // ---- stage p1: buffered sample at the FIFO head ----
  logic [OUT_WIDTH-1:0] q_p1;
  logic                 vld_p1;
  logic                 pop;
  logic [CNT_W-1:0]     count;

  assign vld_p1 = !empty;
  assign pop    = vld_p1 && m_ready_z;

  y_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (vld_p0),
    .wr_data (q_p0),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (q_p1)
  );

  // Frame position of the sample at the head; advances on each output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (pop) begin
      count <= (count == LAST_IDX) ? '0 : count + 1'b1;
    end
  end

  assign m_valid_z    = vld_p1;
  assign m_data_out_z = q_p1;
  assign m_last_z     = vld_p1 && (count == LAST_IDX);

endmodule

// File: tb/tb_y_requant_out.sv
// Directed bench for y_requant_out: rounding/clamping vectors, backpressure
// and full behaviour, frame tagging, mid-frame reset and a randomized stall run.
module tb_y_requant_out;

  localparam int ACC_W = 21;
  localparam int OUT_W = 8;

  logic                    clk;
  logic                    reset;
  logic                    s_valid_y;
  logic                    s_ready_y;
  logic signed [ACC_W-1:0] s_data_in_y;
  logic                    m_valid_z;
  logic                    m_ready_z;
  logic [OUT_W-1:0]        m_data_out_z;
  logic                    m_last_z;

  int errors = 0;
  int checks = 0;

  y_requant_out dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid_y    (s_valid_y),
    .s_ready_y    (s_ready_y),
    .s_data_in_y  (s_data_in_y),
    .m_valid_z    (m_valid_z),
    .m_ready_z    (m_ready_z),
    .m_data_out_z (m_data_out_z),
    .m_last_z     (m_last_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Independent arithmetic reference for SHIFT=7, 8-bit output.
  function automatic int model(input int x);
    int v;
    if (x < 0) return 0;
    v = (x + 64) / 128;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Present one sample and hold it until accepted; returns #1 after the accepting edge.
  task automatic push_one(input int d);
    int n;
    n = 0;
    s_valid_y   = 1'b1;
    s_data_in_y = ACC_W'(d);
    @(negedge clk);
    while (!s_ready_y && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 1, 0);
    @(posedge clk);
    #1 s_valid_y = 1'b0;
  endtask

  // Continuous stream of n samples k*128 (output k) with downstream always ready.
  task automatic stream(input int n, input int base);
    int   in_i;
    int   out_i;
    logic acc;
    in_i = 0;
    out_i = 0;
    m_ready_z = 1'b1;
    for (int c = 0; c < n + 10 && out_i < n; c++) begin
      s_valid_y   = (in_i < n);
      s_data_in_y = ACC_W'(in_i * 128);
      @(negedge clk);
      acc = s_valid_y && s_ready_y;
      if (m_valid_z) begin
        chk("strm_data", m_data_out_z, out_i);
        chk("strm_last", m_last_z, int'((base + out_i) % 97 == 96));
        out_i++;
      end
      @(posedge clk);
      #1;
      if (acc) in_i++;
    end
    s_valid_y = 1'b0;
    chk("strm_count", out_i, n);
  endtask

  int   vin  [6] = '{200, 63, 64, -5, 1048575, -1048576};
  int   vexp [6] = '{2, 0, 1, 0, 255, 0};
  int   got_q[$];
  int   exp_q[$];
  logic acc;
  logic first;
  logic stall_prev;
  int   prev_data;
  int   in_n;
  int   out_n;
  int   cur_x;

  initial begin
    reset       = 1'b0;
    s_valid_y   = 1'b0;
    s_data_in_y = '0;
    m_ready_z   = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", s_ready_y, 1);
    chk("rst_valid", m_valid_z, 0);
    chk("rst_last",  m_last_z, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Rounding, clamping and saturation vectors with one-cycle latency
    m_ready_z = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid_y   = 1'b1;
      s_data_in_y = ACC_W'(vin[i]);
      @(negedge clk);
      chk("vec_pre_valid", m_valid_z, 0);
      chk("vec_ready", s_ready_y, 1);
      @(posedge clk);
      #1 s_valid_y = 1'b0;
      @(negedge clk);
      chk("vec_valid", m_valid_z, 1);
      chk("vec_data", m_data_out_z, vexp[i]);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("vec_drained", m_valid_z, 0);
      @(posedge clk);
      #1;
    end

    // Backpressure: four fill the FIFO, the fifth waits
    m_ready_z = 1'b0;
    s_valid_y = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data_in_y = ACC_W'((10 + i) * 128);
      @(negedge clk);
      chk("bp_ready", s_ready_y, int'(i < 4));
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    chk("bp_stall_data", m_data_out_z, 10);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_hold_valid", m_valid_z, 1);
    chk("bp_hold_data", m_data_out_z, 10);
    @(posedge clk);
    #1 m_ready_z = 1'b1;
    first = 1'b1;
    got_q.delete();
    for (int c = 0; c < 40 && got_q.size() < 5; c++) begin
      @(negedge clk);
      if (first) chk("bp_no_bypass", s_ready_y, 0);
      first = 1'b0;
      acc = s_valid_y && s_ready_y;
      if (m_valid_z) got_q.push_back(int'(m_data_out_z));
      @(posedge clk);
      #1;
      if (acc) s_valid_y = 1'b0;
    end
    chk("bp_count", got_q.size(), 5);
    for (int i = 0; i < got_q.size(); i++) chk("bp_order", got_q[i], 10 + i);

    // Frame tagging across a full frame and the wrap
    do_reset();
    stream(98, 0);

    // Mid-frame reset with two samples buffered at frame index 96
    do_reset();
    stream(96, 0);
    m_ready_z = 1'b0;
    push_one(20 * 128);
    push_one(21 * 128);
    @(negedge clk);
    chk("mr_valid", m_valid_z, 1);
    chk("mr_last", m_last_z, 1);
    chk("mr_data", m_data_out_z, 20);
    #1 reset = 1'b0;
    #1;
    chk("mr_async_valid", m_valid_z, 0);
    chk("mr_async_last", m_last_z, 0);
    chk("mr_async_ready", s_ready_y, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    m_ready_z   = 1'b1;
    s_valid_y   = 1'b1;
    s_data_in_y = ACC_W'(5 * 128);
    @(negedge clk);
    chk("mr_discarded", m_valid_z, 0);
    @(posedge clk);
    #1 s_valid_y = 1'b0;
    @(negedge clk);
    chk("mr_new_valid", m_valid_z, 1);
    chk("mr_new_data", m_data_out_z, 5);
    chk("mr_new_last", m_last_z, 0);
    @(posedge clk);
    #1;
    stream(96, 1);

    // Randomized downstream stalls against a scoreboard
    exp_q.delete();
    in_n = 0;
    out_n = 0;
    stall_prev = 1'b0;
    prev_data = 0;
    s_valid_y = 1'b0;
    cur_x = int'($urandom_range(0, 80000)) - 40000;
    for (int c = 0; c < 2000 && out_n < 40; c++) begin
      if (!s_valid_y) s_valid_y = (in_n < 40) && ($urandom_range(0, 3) != 0);
      s_data_in_y = ACC_W'(cur_x);
      m_ready_z   = $urandom_range(0, 1) != 0;
      @(negedge clk);
      if (stall_prev) begin
        chk("rnd_hold_valid", m_valid_z, 1);
        chk("rnd_hold_data", m_data_out_z, prev_data);
      end
      if (m_valid_z && m_ready_z) begin
        if (exp_q.size() == 0) chk("rnd_extra", m_data_out_z, -1);
        else chk("rnd_data", m_data_out_z, exp_q.pop_front());
        out_n++;
      end
      acc = s_valid_y && s_ready_y;
      if (acc) exp_q.push_back(model(cur_x));
      stall_prev = m_valid_z && !m_ready_z;
      prev_data  = int'(m_data_out_z);
      @(posedge clk);
      #1;
      if (acc) begin
        in_n++;
        s_valid_y = 1'b0;
        cur_x = int'($urandom_range(0, 80000)) - 40000;
      end
    end
    chk("rnd_out_count", out_n, 40);
    chk("rnd_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
